// File: rtl/ysyx_24100029_lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: RISC-V size codes,
// AXI burst/response encodings, controller states and the split test.
package ysyx_24100029_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD1,
      ST_RD2,
      ST_WR1,
      ST_WR2,
      ST_DONE
   } state_t;

   // An access crosses a bus word when its last byte lands past the word end.
   function automatic logic crosses(input int off, input int size_code, input int bytes);
      return (off + (1 << size_code)) > bytes;
   endfunction

endpackage

// File: rtl/ysyx_24100029_lsu_align.sv
// Combinational byte-lane alignment: shifts store data/strobes into a
// two-word window and extracts/extends load bytes from a merged window.
module ysyx_24100029_lsu_align
   import ysyx_24100029_lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]                    funct3,
   input  logic [$clog2(DATA_W/8)-1:0]   off,
   input  logic [DATA_W-1:0]             st_data,
   output logic [DATA_W-1:0]             st_data_lo,
   output logic [DATA_W-1:0]             st_data_hi,
   output logic [DATA_W/8-1:0]           st_strb_lo,
   output logic [DATA_W/8-1:0]           st_strb_hi,
   input  logic [2*DATA_W-1:0]           ld_merged,
   output logic [DATA_W-1:0]             ld_data
);

   localparam int B = DATA_W / 8;

   logic [2*DATA_W-1:0] st_wide;
   logic [2*B-1:0]      strb_mask;
   logic [2*B-1:0]      strb_wide;
   logic [DATA_W-1:0]   ld_shift;
   logic signed [7:0]   ld_b;
   logic signed [15:0]  ld_h;
   logic signed [31:0]  ld_w;

   // Store side: place data and byte enables at the byte offset in a 2-word window
   always_comb begin
      strb_mask = '0;
      for (int i = 0; i < B; i++) begin
         strb_mask[i] = (i < (1 << funct3[1:0]));
      end
      st_wide   = {{DATA_W{1'b0}}, st_data} << {off, 3'b000};
      strb_wide = strb_mask << off;
      {st_data_hi, st_data_lo} = st_wide;
      {st_strb_hi, st_strb_lo} = strb_wide;
   end

   // Load side: bring the addressed bytes to bit 0, then sign/zero-extend
   always_comb begin
      ld_shift = DATA_W'(ld_merged >> {off, 3'b000});
      ld_b     = ld_shift[7:0];
      ld_h     = ld_shift[15:0];
      ld_w     = ld_shift[31:0];
      case (funct3)
         F3_B:    ld_data = DATA_W'(ld_b);
         F3_H:    ld_data = DATA_W'(ld_h);
         F3_W:    ld_data = DATA_W'(ld_w);
         F3_BU:   ld_data = DATA_W'(ld_shift[7:0]);
         F3_HU:   ld_data = DATA_W'(ld_shift[15:0]);
         F3_WU:   ld_data = DATA_W'(ld_shift[31:0]);
         default: ld_data = ld_shift;
      endcase
   end

endmodule

// File: rtl/ysyx_24100029_lsu_split.sv
// MEM-stage AXI4 load/store unit. One op per EX handshake, single-beat AXI
// transactions, word-crossing accesses split into two beats and merged.
module ysyx_24100029_lsu_split
   import ysyx_24100029_lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4,
   parameter int RD_ID  = 0,
   parameter int WR_ID  = 1,
   parameter int SIDE_W = 72
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_ren,
   input  logic                in_wen,
   input  logic [2:0]          in_funct3,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DATA_W-1:0]   in_wdata,
   input  logic [SIDE_W-1:0]   in_side,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_rdata,
   output logic                out_fault,
   output logic [SIDE_W-1:0]   out_side,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [ID_W-1:0]     awid,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   input  logic [ID_W-1:0]     bid,
   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   output logic [ID_W-1:0]     arid,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic [ID_W-1:0]     rid
);

   localparam int B     = DATA_W / 8;
   localparam int OFF_W = $clog2(B);

   state_t              state;
   logic                issued;
   logic                split_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          funct3_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   lo_q;
   logic                second;
   logic [ADDR_W-1:0]   base_addr;
   logic [ADDR_W-1:0]   beat_addr;
   logic [2:0]          beat_size;
   logic [DATA_W-1:0]   st_data_lo;
   logic [DATA_W-1:0]   st_data_hi;
   logic [B-1:0]        st_strb_lo;
   logic [B-1:0]        st_strb_hi;
   logic [2*DATA_W-1:0] ld_merged;
   logic [DATA_W-1:0]   ld_data;
   logic                unused;

   assign unused = ^{bid, rid, rlast};

   // Beat address/size are pure functions of the latched op and current beat
   assign second    = (state == ST_RD2) || (state == ST_WR2);
   assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign beat_addr = !split_q ? addr_q : (second ? base_addr + ADDR_W'(B) : base_addr);
   assign beat_size = split_q ? 3'(OFF_W) : {1'b0, funct3_q[1:0]};
   assign ld_merged = second ? {rdata, lo_q} : {{DATA_W{1'b0}}, rdata};

   assign awaddr  = beat_addr;
   assign awsize  = beat_size;
   assign awid    = ID_W'(WR_ID);
   assign awlen   = 8'd0;
   assign awburst = BURST_INCR;
   assign wdata   = second ? st_data_hi : st_data_lo;
   assign wstrb   = second ? st_strb_hi : st_strb_lo;
   assign wlast   = 1'b1;
   assign araddr  = beat_addr;
   assign arsize  = beat_size;
   assign arid    = ID_W'(RD_ID);
   assign arlen   = 8'd0;
   assign arburst = BURST_INCR;

   ysyx_24100029_lsu_align #(
      .DATA_W(DATA_W)
   ) u_align (
      .funct3     (funct3_q),
      .off        (addr_q[OFF_W-1:0]),
      .st_data    (wdata_q),
      .st_data_lo (st_data_lo),
      .st_data_hi (st_data_hi),
      .st_strb_lo (st_strb_lo),
      .st_strb_hi (st_strb_hi),
      .ld_merged  (ld_merged),
      .ld_data    (ld_data)
   );

   // Op payload and first load beat; consumed only after being written
   always_ff @(posedge clock) begin
      if (in_valid && in_ready) begin
         addr_q   <= in_addr;
         funct3_q <= in_funct3;
         wdata_q  <= in_wdata;
      end
      if (rvalid && rready && (state == ST_RD1)) begin
         lo_q <= rdata;
      end
   end

   // Controller: accept, issue one or two AXI beats, present result to WB
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         issued    <= 1'b0;
         split_q   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_rdata <= '0;
         out_fault <= 1'b0;
         out_side  <= '0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready  <= 1'b0;
                  issued    <= 1'b0;
                  out_fault <= 1'b0;
                  out_side  <= in_side;
                  split_q   <= crosses(int'(in_addr[OFF_W-1:0]), int'(in_funct3[1:0]), B);
                  state     <= in_ren ? ST_RD1 : (in_wen ? ST_WR1 : ST_DONE);
               end
            end
            ST_RD1, ST_RD2: begin
               if (!issued) begin
                  arvalid <= 1'b1;
                  rready  <= 1'b1;
                  issued  <= 1'b1;
               end else begin
                  if (arready) arvalid <= 1'b0;
                  if (rvalid && rready) begin
                     rready <= 1'b0;
                     issued <= 1'b0;
                     if (rresp != RESP_OKAY) begin
                        out_fault <= 1'b1;
                        out_rdata <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                     end else if ((state == ST_RD1) && split_q) begin
                        state <= ST_RD2;
                     end else begin
                        out_rdata <= ld_data;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                     end
                  end
               end
            end
            ST_WR1, ST_WR2: begin
               if (!issued) begin
                  awvalid <= 1'b1;
                  wvalid  <= 1'b1;
                  issued  <= 1'b1;
               end else begin
                  if (awready) awvalid <= 1'b0;
                  if (wready) wvalid <= 1'b0;
                  if (!bready && (!awvalid || awready) && (!wvalid || wready)) bready <= 1'b1;
                  if (bvalid && bready) begin
                     bready <= 1'b0;
                     issued <= 1'b0;
                     if (bresp != RESP_OKAY) begin
                        out_fault <= 1'b1;
                        out_rdata <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                     end else if ((state == ST_WR1) && split_q) begin
                        state <= ST_WR2;
                     end else begin
                        out_rdata <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (!out_valid) begin
                  out_rdata <= '0;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24100029_lsu_split.sv
// Directed bench for the load/store unit: 32-bit instance against a reactive
// AXI slave, plus a 64-bit instance for a full doubleword load.
`timescale 1ns/1ps
module tb_ysyx_24100029_lsu_split;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc;

   // 32-bit instance signals
   logic        in_valid, in_ready, in_ren, in_wen;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic [71:0] in_side;
   logic        out_valid, out_ready, out_fault;
   logic [31:0] out_rdata;
   logic [71:0] out_side;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [31:0] awaddr, wdata;
   logic [3:0]  awid, bid, arid, rid, wstrb;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] araddr, rdata;

   // 64-bit instance signals
   logic        d64_in_valid, d64_in_ready, d64_in_ren, d64_in_wen;
   logic [2:0]  d64_in_funct3;
   logic [31:0] d64_in_addr;
   logic [63:0] d64_in_wdata;
   logic [71:0] d64_in_side;
   logic        d64_out_valid, d64_out_ready, d64_out_fault;
   logic [63:0] d64_out_rdata;
   logic [71:0] d64_out_side;
   logic        d64_awvalid, d64_wvalid, d64_wlast, d64_bready;
   logic        d64_awready = 1'b0, d64_wready = 1'b0, d64_bvalid = 1'b0;
   logic [31:0] d64_awaddr, d64_araddr;
   logic [63:0] d64_wdata, d64_rdata;
   logic [7:0]  d64_wstrb, d64_awlen, d64_arlen;
   logic [3:0]  d64_awid, d64_arid;
   logic [3:0]  d64_bid = 4'd0, d64_rid = 4'd0;
   logic [2:0]  d64_awsize, d64_arsize;
   logic [1:0]  d64_awburst, d64_arburst;
   logic [1:0]  d64_bresp = 2'b00, d64_rresp = 2'b00;
   logic        d64_arvalid, d64_arready, d64_rvalid, d64_rready;
   logic        d64_rlast = 1'b1;
   logic [31:0] d64_ar_seen;
   logic [2:0]  d64_arsz_seen;

   ysyx_24100029_lsu_split #(.DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_side(in_side),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_fault(out_fault), .out_side(out_side),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
   );

   ysyx_24100029_lsu_split #(.DATA_W(64)) dut64 (
      .clock(clock), .reset(reset),
      .in_valid(d64_in_valid), .in_ready(d64_in_ready), .in_ren(d64_in_ren), .in_wen(d64_in_wen),
      .in_funct3(d64_in_funct3), .in_addr(d64_in_addr), .in_wdata(d64_in_wdata), .in_side(d64_in_side),
      .out_valid(d64_out_valid), .out_ready(d64_out_ready), .out_rdata(d64_out_rdata),
      .out_fault(d64_out_fault), .out_side(d64_out_side),
      .awvalid(d64_awvalid), .awready(d64_awready), .awaddr(d64_awaddr), .awid(d64_awid),
      .awlen(d64_awlen), .awsize(d64_awsize), .awburst(d64_awburst),
      .wvalid(d64_wvalid), .wready(d64_wready), .wdata(d64_wdata), .wstrb(d64_wstrb), .wlast(d64_wlast),
      .bvalid(d64_bvalid), .bready(d64_bready), .bresp(d64_bresp), .bid(d64_bid),
      .arvalid(d64_arvalid), .arready(d64_arready), .araddr(d64_araddr), .arid(d64_arid),
      .arlen(d64_arlen), .arsize(d64_arsize), .arburst(d64_arburst),
      .rvalid(d64_rvalid), .rready(d64_rready), .rdata(d64_rdata), .rresp(d64_rresp),
      .rlast(d64_rlast), .rid(d64_rid)
   );

   // Slave-side queues: responses to hand out and transactions observed
   logic [31:0] rd_data_q[$];
   logic [1:0]  rd_resp_q[$];
   logic [1:0]  wr_resp_q[$];
   logic [31:0] ar_log[$];
   logic [2:0]  arsz_log[$];
   logic [31:0] aw_log[$];
   logic [31:0] wd_log[$];
   logic [3:0]  ws_log[$];
   logic        wl_log[$];
   bit          slave_off = 1'b0;
   int          rd_lat = 3;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      rd_data_q.delete(); rd_resp_q.delete(); wr_resp_q.delete();
      ar_log.delete(); arsz_log.delete(); aw_log.delete();
      wd_log.delete(); ws_log.delete(); wl_log.delete();
   endtask

   task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [71:0] side);
      @(negedge clock);
      for (int k = 0; k < 100 && !in_ready; k++) @(negedge clock);
      chk("in_ready_before_issue", in_ready, 1);
      in_valid = 1'b1; in_ren = ren; in_wen = wen; in_funct3 = f3;
      in_addr = addr; in_wdata = wd; in_side = side;
      @(posedge clock);
      #1;
      in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 300) begin
         @(posedge clock);
         #1 n++;
      end
      chk("out_valid_arrives", out_valid, 1);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clock);
      #1 out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
   endtask

   // Read slave for the 32-bit instance
   initial begin
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rid = '0;
      forever begin
         @(negedge clock);
         if (arvalid && !slave_off && !reset) begin
            arready = 1'b1;
            ar_log.push_back(araddr);
            arsz_log.push_back(arsize);
            @(negedge clock);
            arready = 1'b0;
            repeat (rd_lat - 1) @(negedge clock);
            rvalid = 1'b1;
            rdata  = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 32'h0;
            rresp  = (rd_resp_q.size() != 0) ? rd_resp_q.pop_front() : 2'b00;
            for (int k = 0; k < 50 && !rready; k++) @(negedge clock);
            @(posedge clock);
            #1 rvalid = 1'b0;
         end
      end
   end

   // Write slave for the 32-bit instance
   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
      forever begin
         @(negedge clock);
         if (awvalid && wvalid && !reset) begin
            aw_log.push_back(awaddr);
            wd_log.push_back(wdata);
            ws_log.push_back(wstrb);
            wl_log.push_back(wlast);
            awready = 1'b1; wready = 1'b1;
            @(negedge clock);
            awready = 1'b0; wready = 1'b0;
            bvalid = 1'b1;
            bresp  = (wr_resp_q.size() != 0) ? wr_resp_q.pop_front() : 2'b00;
            for (int k = 0; k < 50 && !bready; k++) @(negedge clock);
            @(posedge clock);
            #1 bvalid = 1'b0;
         end
      end
   end

   // Read slave for the 64-bit instance: fixed doubleword, one-cycle latency
   initial begin
      d64_arready = 1'b0; d64_rvalid = 1'b0; d64_rdata = 64'h0123_4567_89AB_CDEF;
      d64_ar_seen = '0; d64_arsz_seen = '0;
      forever begin
         @(negedge clock);
         if (d64_arvalid && !reset) begin
            d64_arready = 1'b1;
            d64_ar_seen = d64_araddr;
            d64_arsz_seen = d64_arsize;
            @(negedge clock);
            d64_arready = 1'b0;
            d64_rvalid = 1'b1;
            for (int k = 0; k < 50 && !d64_rready; k++) @(negedge clock);
            @(posedge clock);
            #1 d64_rvalid = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      in_valid = 0; in_ren = 0; in_wen = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0; in_side = 0;
      out_ready = 0;
      d64_in_valid = 0; d64_in_ren = 0; d64_in_wen = 0; d64_in_funct3 = 0;
      d64_in_addr = 0; d64_in_wdata = 0; d64_in_side = 0; d64_out_ready = 0;

      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rdata", out_rdata, 0);
      chk("rst_out_fault", out_fault, 0);
      chk("rst_out_side", out_side[71:8], 0);
      chk("rst_axi_handshakes", {arvalid, rready, awvalid, wvalid, bready}, 0);
      chk("rst_d64_in_ready", d64_in_ready, 1);
      @(negedge clock);
      reset = 1'b0;

      // lw aligned
      clear_logs();
      rd_data_q.push_back(32'hDEADBEEF);
      issue(1, 0, 3'b010, 32'h8000_0004, 0, 72'hA5_0000_0000_0000_1111);
      wait_out(cyc);
      chk("lw_ar_count", ar_log.size(), 1);
      chk("lw_araddr", ar_log[0], 32'h8000_0004);
      chk("lw_arsize", arsz_log[0], 2);
      chk("lw_arid_len_burst", {arid, arlen, arburst}, {4'd0, 8'd0, 2'b01});
      chk("lw_rdata", out_rdata, 32'hDEADBEEF);
      chk("lw_fault", out_fault, 0);
      chk("lw_side", out_side[71:8], 64'hA5_0000_0000_0000_11);
      take();

      // lb / lbu at the top byte lane
      clear_logs();
      rd_data_q.push_back(32'h80FF_FFFF);
      issue(1, 0, 3'b000, 32'h8000_0003, 0, 0);
      wait_out(cyc);
      chk("lb_araddr", ar_log[0], 32'h8000_0003);
      chk("lb_arsize", arsz_log[0], 0);
      chk("lb_rdata", out_rdata, 32'hFFFF_FF80);
      take();
      clear_logs();
      rd_data_q.push_back(32'h80FF_FFFF);
      issue(1, 0, 3'b100, 32'h8000_0003, 0, 0);
      wait_out(cyc);
      chk("lbu_rdata", out_rdata, 32'h0000_0080);
      take();

      // lh sign-extended from the upper half
      clear_logs();
      rd_data_q.push_back(32'h8001_0000);
      issue(1, 0, 3'b001, 32'h8000_0002, 0, 0);
      wait_out(cyc);
      chk("lh_arsize", arsz_log[0], 1);
      chk("lh_rdata", out_rdata, 32'hFFFF_8001);
      take();

      // Split lw across two words
      clear_logs();
      rd_data_q.push_back(32'h1122_AAAA);
      rd_data_q.push_back(32'hBBBB_3344);
      issue(1, 0, 3'b010, 32'h8000_0006, 0, 0);
      wait_out(cyc);
      chk("split_lw_ar_count", ar_log.size(), 2);
      chk("split_lw_araddr0", ar_log[0], 32'h8000_0004);
      chk("split_lw_araddr1", ar_log[1], 32'h8000_0008);
      chk("split_lw_arsize", {arsz_log[0], arsz_log[1]}, {3'd2, 3'd2});
      chk("split_lw_rdata", out_rdata, 32'h3344_1122);
      chk("split_lw_fault", out_fault, 0);
      take();

      // Aligned load with error response
      clear_logs();
      rd_data_q.push_back(32'h1234_5678);
      rd_resp_q.push_back(2'b11);
      issue(1, 0, 3'b010, 32'h8000_0010, 0, 0);
      wait_out(cyc);
      chk("lw_err_fault", out_fault, 1);
      chk("lw_err_rdata", out_rdata, 0);
      take();

      // Split sh
      clear_logs();
      issue(0, 1, 3'b001, 32'h8000_0003, 32'h0000_ABCD, 0);
      wait_out(cyc);
      chk("split_sh_aw_count", aw_log.size(), 2);
      chk("split_sh_awaddr0", aw_log[0], 32'h8000_0000);
      chk("split_sh_wstrb0", ws_log[0], 4'b1000);
      chk("split_sh_wdata0_top", wd_log[0][31:24], 8'hCD);
      chk("split_sh_awaddr1", aw_log[1], 32'h8000_0004);
      chk("split_sh_wstrb1", ws_log[1], 4'b0001);
      chk("split_sh_wdata1_low", wd_log[1][7:0], 8'hAB);
      chk("split_sh_wlast", {wl_log[0], wl_log[1]}, 2'b11);
      chk("split_sh_awid_size", {awid, awsize}, {4'd1, 3'd2});
      chk("split_sh_rdata", out_rdata, 0);
      chk("split_sh_fault", out_fault, 0);
      take();

      // Split sw whose first beat errors; then WB stalls
      clear_logs();
      wr_resp_q.push_back(2'b10);
      issue(0, 1, 3'b010, 32'h8000_0002, 32'h1234_5678, 72'h3C_0000_0000_0000_2222);
      wait_out(cyc);
      chk("fault_sw_fault", out_fault, 1);
      chk("fault_sw_rdata", out_rdata, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         chk("stall_out_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_fault", out_fault, 1);
         chk("stall_side", out_side[71:8], 64'h3C_0000_0000_0000_22);
      end
      chk("fault_sw_aw_count", aw_log.size(), 1);
      take();

      // Pass-through: cycles counted from the accept cycle to the out_valid cycle
      clear_logs();
      issue(0, 0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 72'h77_0000_0000_0000_3333);
      wait_out(cyc);
      chk("pass_latency", cyc + 1, 2);
      chk("pass_rdata", out_rdata, 0);
      chk("pass_fault", out_fault, 0);
      chk("pass_side", out_side[71:8], 64'h77_0000_0000_0000_33);
      chk("pass_no_axi", ar_log.size() + aw_log.size(), 0);
      take();

      // Asynchronous reset while a read address is outstanding
      clear_logs();
      slave_off = 1'b1;
      issue(1, 0, 3'b010, 32'h8000_0020, 0, 0);
      for (int k = 0; k < 20 && !arvalid; k++) begin
         @(posedge clock);
         #1;
      end
      chk("mid_arvalid_up", arvalid, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_arvalid", arvalid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_rready", rready, 0);
      @(negedge clock);
      reset = 1'b0;
      slave_off = 1'b0;

      // 64-bit doubleword load
      @(negedge clock);
      chk("d64_in_ready", d64_in_ready, 1);
      d64_in_valid = 1'b1; d64_in_ren = 1'b1; d64_in_funct3 = 3'b011;
      d64_in_addr = 32'h8000_0008;
      @(posedge clock);
      #1 d64_in_valid = 1'b0; d64_in_ren = 1'b0;
      cyc = 0;
      while (!d64_out_valid && cyc < 200) begin
         @(posedge clock);
         #1 cyc++;
      end
      chk("d64_out_valid", d64_out_valid, 1);
      chk("d64_araddr", d64_ar_seen, 32'h8000_0008);
      chk("d64_arsize", d64_arsz_seen, 3);
      chk("d64_rdata", d64_out_rdata, 64'h0123_4567_89AB_CDEF);
      chk("d64_fault", d64_out_fault, 0);
      d64_out_ready = 1'b1;
      @(posedge clock);
      #1 d64_out_ready = 1'b0;
      chk("d64_out_valid_drop", d64_out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_24100029_lsu_split.md
Name: ysyx_24100029_lsu_split

Overview:
- Parametrised AXI4 load/store unit for the MEM stage.
- Accepts one memory op per handshake from EX and issues single-beat AXI4 transactions.
- Splits misaligned accesses that cross a bus-word boundary into two beats and merges the result.
- Returns sign/zero-extended load data, or a fault flag, to WB with a registered valid/ready handshake; a sideband bundle (pc, rd, wen flags…) is carried alongside unchanged.

Parameters:
- DATA_W, 32, bus/XLEN width; 32 or 64 only.
- ADDR_W, 32, address width.
- ID_W, 4, AXI ID width.
- RD_ID, 0, arid value.
- WR_ID, 1, awid value.
- SIDE_W, 72, width of the opaque sideband passed EX→WB.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset; all state cleared immediately
- in_valid/in_ready  in/out  1/1  upstream handshake
- in_ren, in_wen  in  1/1  load / store request; neither set = pass-through
- in_funct3  in  3  RISC-V size/sign code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- in_addr  in  ADDR_W  byte address
- in_wdata  in  DATA_W  store data, LSB-aligned
- in_side  in  SIDE_W  sideband
- out_valid/out_ready  out/in  1/1  downstream handshake
- out_rdata  out  DATA_W  extended load data; 0 for stores and pass-through
- out_fault  out  1  an AXI response beat had resp≠OKAY
- out_side  out  SIDE_W  registered sideband
- aw*/w*/b*/ar*/r*  AXI4 master: awvalid, awready, awaddr, awid, awlen, awsize, awburst, wvalid, wready, wdata, wstrb, wlast, bvalid, bready, bresp, bid, arvalid, arready, araddr, arid, arlen, arsize, arburst, rvalid, rready, rdata, rresp, rlast, rid

Behaviour:
- Reset values: in_ready=1; out_valid=0; out_rdata=0; out_fault=0; out_side=0; all AXI valids/readys=0.
- State machine: IDLE, RD1, RD2, WR1, WR2, DONE.
- IDLE:
  - in_ready=1.
  - On accept, latch all inputs. Next state: RD1 if ren, WR1 if wen, DONE otherwise. ren and wen both set is illegal; ren has priority.
- Byte count and beat decision:
  - n=2^funct3[1:0]; funct3 011/110 are legal only when DATA_W=64.
  - B=DATA_W/8; off=addr mod B.
  - Split when off+n>B.
- Aligned access: one beat at addr; size field=funct3[1:0]; len=0; burst=INCR(01).
- Split access: beat1 at addr−off, beat2 at addr−off+B; size=log2(B) for both.
- Read path:
  - arvalid rises the cycle after entering RD1/RD2 and drops on arready.
  - rready=1 in RD1/RD2 until the rvalid handshake.
  - Beat1 data is stored; beat2 low bytes are concatenated above it.
  - Result bytes = merged[off*8 +: n*8], then sign/zero-extended per funct3.
- Write path:
  - wdata = in_wdata<<(8*off); wstrb = ((1<<n)−1)<<off, taken over a 2B-wide window.
  - Beat1 uses the low B bytes/strobes; beat2 uses the high ones.
  - wlast=1 on every beat.
  - awvalid and wvalid assert together; each drops independently on its own ready.
  - bready=1 after both handshakes, until bvalid.
- Faults:
  - Any rresp/bresp≠00 sets fault.
  - A faulting beat1 skips beat2 and goes straight to DONE; out_rdata=0 on a faulting load.
- DONE:
  - out_valid=1 with registered outputs; held stable until out_ready.
  - On handshake: out_valid=0 and return to IDLE. No accept occurs in the same cycle, so one bubble per op.
- Latency:
  - Pass-through = 2 cycles from accept to out_valid.
  - Aligned op = accept + 1 + AXI latency + 1.
- rid/bid/rlast are ignored. rvalid outside RD states has no effect.
- Reset mid-transaction: all valids drop asynchronously and state returns to IDLE; the interconnect is reset by the same signal.

Decomposition:
- Shared package ysyx_24100029_lsu_pkg holds:
  - funct3 size/sign constants;
  - AXI burst/resp constants (INCR=2'b01, OKAY=2'b00);
  - state encoding.
- One natural sub-module, ysyx_24100029_lsu_align. It is combinational and performs:
  - strobe/data shifting for stores;
  - byte extraction with sign/zero extension for loads.
  - It is parametrised by DATA_W and shared with a later cache path.

Test Plan:
- DATA_W=32, lw 0x80000004, slave returns 0xDEADBEEF after 3 cycles → one AR (araddr=0x80000004, arsize=2); out_rdata=0xDEADBEEF; out_fault=0.
- lb at 0x80000003, rdata=0x80FFFFFF → out_rdata=0xFFFFFF80; same with lbu → 0x00000080.
- lw at 0x80000006, beats 0x1122_xxxx then 0xxxxx_3344 → two ARs (0x80000004, 0x80000008, arsize=2); out_rdata=0x33441122.
- sh 0x0000ABCD at 0x80000003 → beat1 wstrb=1000, wdata[31:24]=0xCD; beat2 addr 0x80000004, wstrb=0001, wdata[7:0]=0xAB; one B per beat.
- Split store with beat1 bresp=2'b10 → no second AW; out_fault=1. Then out_ready held low 5 cycles → outputs stable and in_ready=0 throughout.
- reset pulsed while arvalid=1 → arvalid=0 and in_ready=1 immediately, with no clock edge needed. A DATA_W=64 ld at 0x...8 afterwards returns the full 64-bit word.
